// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed-latency IDLE/WAIT/RESP handshake for the M-stage.
// Optional DMEM_FAST_WRITE_EN: stores complete one cycle after acceptance.
module dmem_responder #(
   parameter int LEN_WORD     = 32,
   parameter int LEN_MEM_ADDR = 8,
   parameter int WAIT_CYCLES  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [LEN_WORD-1:0] addr,
   input  logic [LEN_WORD-1:0] write_data,
   output logic [LEN_WORD-1:0] read_data,
   output logic                ready,
   output logic                busy,
   output logic                err
);

   localparam int AW = LEN_MEM_ADDR + 2;
   localparam int DEPTH = 2 ** LEN_MEM_ADDR;
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic                  busy_q;
   logic                  store_q;
   logic                  err_q;
   logic [AW-1:0]         addr_q;
   logic [LEN_WORD-1:0]   wdata_q;
   logic [LEN_WORD-1:0]   rdata_q;
   logic [LEN_WORD-1:0]   mem [0:DEPTH-1];

   logic                  req;
   logic                  direct_resp;
   logic                  cur_store;
   logic [AW-1:0]         cur_addr;
   logic [LEN_WORD-1:0]   cur_wdata;
   logic                  commit;
   logic                  mem_we;
   logic                  mem_re;
   logic [LEN_MEM_ADDR-1:0] word_idx;

   // Address bits above the word index wrap around and are intentionally dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, addr[LEN_WORD-1:AW]};

   assign req = mem_read | mem_write;

   // In IDLE the access can commit on the acceptance edge, so use live inputs there.
   always_comb begin
      direct_resp = (WAIT_CYCLES == 0);
`ifdef DMEM_FAST_WRITE_EN
      direct_resp = (WAIT_CYCLES == 0) || mem_write;
`endif
      cur_store = store_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      if (state_q == S_IDLE) begin
         cur_store = mem_write;
         cur_addr  = addr[AW-1:0];
         cur_wdata = write_data;
      end
      commit = !reset &&
               (((state_q == S_IDLE) && req && direct_resp) ||
                ((state_q == S_WAIT) && (cnt_q == 4'd0)));
      mem_we   = commit && cur_store && (cur_addr[1:0] == 2'b00);
      mem_re   = commit && !cur_store && (cur_addr[1:0] == 2'b00);
      word_idx = cur_addr[AW-1:2];
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[word_idx] <= cur_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (mem_re) begin
         rdata_q <= mem[word_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
         store_q <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  // Both strobes high resolves to a store flagged as an error.
                  store_q <= mem_write;
                  err_q   <= (mem_read & mem_write) | (addr[1:0] != 2'b00);
                  addr_q  <= addr[AW-1:0];
                  wdata_q <= write_data;
                  busy_q  <= 1'b1;
                  if (direct_resp) begin
                     state_q <= S_RESP;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= CNT_LOAD;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign read_data = rdata_q;
   assign busy      = busy_q;
   assign ready     = (state_q == S_RESP);
   assign err       = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed checks of dmem_responder against an array-based memory model.
module tb_dmem_responder;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write;
   logic [31:0] addr, write_data;
   logic [31:0] read_data;
   logic        ready, busy, err;

   int errors = 0;
   int checks = 0;

   logic [31:0] model [0:255];
   logic [31:0] exp_rdata = 32'h0;

   always #5 clk = ~clk;

   dmem_responder #(.LEN_WORD(32), .LEN_MEM_ADDR(8), .WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .write_data(write_data), .read_data(read_data),
      .ready(ready), .busy(busy), .err(err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic int exp_latency(input logic wr);
`ifdef DMEM_FAST_WRITE_EN
      if (wr) return 1;
`endif
      return W + 1;
   endfunction

   // Entered #1 after a rising edge with the DUT in IDLE; leaves #1 after the edge ending RESP.
   task automatic xact(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      int k;
      int lat;
      logic b0;
      logic busy_bad;
      logic exp_err;
      mem_read = rd; mem_write = wr; addr = a; write_data = d;
      lat = exp_latency(wr);
      exp_err = (a[1:0] != 2'b00) || (rd && wr);
      if (a[1:0] == 2'b00) begin
         if (wr) model[a[9:2]] = d;
         else exp_rdata = model[a[9:2]];
      end
      b0 = 1'bx;
      busy_bad = 1'b0;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0) b0 = busy;
         else if (busy !== 1'b1) busy_bad = 1'b1;
         if (ready === 1'b1) break;
      end
      $display("xact rd=%0b wr=%0b addr=%h wdata=%h ready_after=%0d rdata=%h err=%0b",
               rd, wr, a, d, k, read_data, err);
      check("latency", 32'(k), 32'(lat));
      check("busy_idle", {31'b0, b0}, 32'd0);
      check("busy_wait", {31'b0, busy_bad}, 32'd0);
      if (k < 20) begin
         check("err", {31'b0, err}, {31'b0, exp_err});
         check("read_data", read_data, exp_rdata);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] a, d;
      int lat;
      logic saw_ready;
      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; write_data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_ready", {31'b0, ready}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_rdata", read_data, 32'd0);
      @(posedge clk); #1;

      // Known contents for the word pool used below.
      for (int i = 0; i < 16; i++) xact(1'b0, 1'b1, 32'(i) << 2, $urandom);

      xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      xact(1'b1, 1'b0, 32'h10, 32'h0);
      xact(1'b1, 1'b0, 32'h13, 32'h0);
      xact(1'b1, 1'b1, 32'h20, 32'h12345678);
      xact(1'b1, 1'b0, 32'h20, 32'h0);
      xact(1'b0, 1'b1, 32'h404, 32'h55);
      xact(1'b1, 1'b0, 32'h004, 32'h0);

      // Reset lands on the store's commit edge: nothing written, no ready.
      mem_read = 1'b0; mem_write = 1'b1; addr = 32'h30; write_data = 32'hCAFEF00D;
      lat = exp_latency(1'b1);
      saw_ready = 1'b0;
      for (int j = 0; j < lat - 1; j++) begin
         @(negedge clk);
         if (ready) saw_ready = 1'b1;
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(negedge clk);
      if (ready) saw_ready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; mem_write = 1'b0;
      exp_rdata = 32'h0;
      @(negedge clk);
      if (ready) saw_ready = 1'b1;
      check("rstmid_ready", {31'b0, saw_ready}, 32'd0);
      check("rstmid_busy", {31'b0, busy}, 32'd0);
      check("rstmid_rdata", read_data, 32'd0);
      @(posedge clk); #1;
      xact(1'b1, 1'b0, 32'h30, 32'h0);

      for (int i = 0; i < 4; i++) xact(1'b1, 1'b0, 32'(i) << 2, 32'h0);

      for (int i = 0; i < 40; i++) begin
         int op;
         op = $urandom_range(0, 5);
         a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
         if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
         d = $urandom;
         if (op < 3) xact(1'b1, 1'b0, a, d);
         else if (op < 5) xact(1'b0, 1'b1, a, d);
         else xact(1'b1, 1'b1, a, d);
         if ($urandom_range(0, 3) == 0) begin
            mem_read = 1'b0; mem_write = 1'b0;
            @(posedge clk); #1;
         end
      end

      mem_read = 1'b0; mem_write = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
